axi_burst_slave_mem: RTL and testbench

- AXI4 burst responder: the slave/DRAM end of the same AXI4 master interface the GLCM core drives.
- Serves INCR read and write bursts from an internal word-addressed memory.
- Used as a synthesizable DRAM stand-in for the GLCM system and for FPGA bring-up.
- Read and write channels are independent; at most one outstanding burst per channel.

---
 rtl/axi_burst_slave_mem.sv | 272 +++++++++++++++++++++++++++
 tb/tb_axi_burst_slave_mem.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_slave_mem.sv
// axi_burst_slave_mem
//   AXI4 burst responder backed by an internal word-addressed memory.
//   Serves INCR read and write bursts (4-byte beats). Read and write
//   channels are independent, with one outstanding burst per channel.
//   Memory base byte address is 0; word index = addr[ADDR_WIDTH-1:2].
//
//   Build option:
//     AXI_RD_LATENCY_EN - inserts R_WAIT so the first read beat appears
//                         READ_LATENCY+1 cycles after the AR handshake.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     aw*_s_inf           write address channel (id, addr, len, size, burst)
//     w*_s_inf            write data channel (data, last, valid/ready)
//     b*_s_inf            write response channel (id, resp, valid/ready)
//     ar*_s_inf           read address channel (id, addr, len, size, burst)
//     r*_s_inf            read data channel (id, data, resp, last, valid/ready)
module axi_burst_slave_mem #(
  parameter int ID_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_WORDS    = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   awid_s_inf,
  input  logic [ADDR_WIDTH-1:0] awaddr_s_inf,
  input  logic [3:0]            awlen_s_inf,
  input  logic [2:0]            awsize_s_inf,
  input  logic [1:0]            awburst_s_inf,
  input  logic                  awvalid_s_inf,
  output logic                  awready_s_inf,
  input  logic [DATA_WIDTH-1:0] wdata_s_inf,
  input  logic                  wlast_s_inf,
  input  logic                  wvalid_s_inf,
  output logic                  wready_s_inf,
  output logic [ID_WIDTH-1:0]   bid_s_inf,
  output logic [1:0]            bresp_s_inf,
  output logic                  bvalid_s_inf,
  input  logic                  bready_s_inf,
  input  logic [ID_WIDTH-1:0]   arid_s_inf,
  input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
  input  logic [3:0]            arlen_s_inf,
  input  logic [2:0]            arsize_s_inf,
  input  logic [1:0]            arburst_s_inf,
  input  logic                  arvalid_s_inf,
  output logic                  arready_s_inf,
  output logic [ID_WIDTH-1:0]   rid_s_inf,
  output logic [DATA_WIDTH-1:0] rdata_s_inf,
  output logic [1:0]            rresp_s_inf,
  output logic                  rlast_s_inf,
  output logic                  rvalid_s_inf,
  input  logic                  rready_s_inf
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int MA_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [IDX_W-1:0] MEM_LIMIT = IDX_W'(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic unused_bits;
  assign unused_bits = ^{awaddr_s_inf[1:0], araddr_s_inf[1:0]};

  // ---------------------------------------------------------------- write
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  wstate_t w_state, w_next;

  logic [ID_WIDTH-1:0] w_id;
  logic [IDX_W-1:0]    w_idx;
  logic [3:0]          w_len;
  logic [3:0]          w_cnt;
  logic                w_err;
  logic                w_bad;   // unsupported size/burst: accept, never store
  logic                w_over;  // all len+1 beats already taken
  logic                aw_hs, w_hs, w_inrange, w_store, bad_aw;

  assign aw_hs     = awvalid_s_inf && awready_s_inf;
  assign w_hs      = wvalid_s_inf && wready_s_inf;
  assign w_inrange = (w_idx < MEM_LIMIT);
  assign w_store   = w_hs && w_inrange && !w_bad && !w_over;
  assign bad_aw    = (awsize_s_inf != 3'b010) || (awburst_s_inf != 2'b01);

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next        = w_state;
    awready_s_inf = 1'b0;
    wready_s_inf  = 1'b0;
    bvalid_s_inf  = 1'b0;
    bresp_s_inf   = 2'b00;
    case (w_state)
      W_IDLE: begin
        awready_s_inf = 1'b1;
        if (awvalid_s_inf) w_next = W_DATA;
      end
      W_DATA: begin
        wready_s_inf = 1'b1;
        if (wvalid_s_inf && wlast_s_inf) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid_s_inf = 1'b1;
        bresp_s_inf  = w_err ? 2'b10 : 2'b00;
        if (bready_s_inf) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign bid_s_inf = w_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_id   <= '0;
      w_idx  <= '0;
      w_len  <= '0;
      w_cnt  <= '0;
      w_err  <= 1'b0;
      w_bad  <= 1'b0;
      w_over <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_id   <= awid_s_inf;
        w_idx  <= awaddr_s_inf[ADDR_WIDTH-1:2];
        w_len  <= awlen_s_inf;
        w_cnt  <= '0;
        w_err  <= bad_aw;
        w_bad  <= bad_aw;
        w_over <= 1'b0;
      end
      if (w_hs) begin
        w_idx <= w_idx + IDX_W'(1);
        w_cnt <= w_cnt + 4'd1;
        if (w_over || !w_inrange)           w_err  <= 1'b1;
        if (w_cnt == w_len)                 w_over <= 1'b1;
        if (wlast_s_inf && (w_cnt != w_len)) w_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) mem[w_idx[MA_W-1:0]] <= wdata_s_inf;
  end

  // ----------------------------------------------------------------- read
`ifdef AXI_RD_LATENCY_EN
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
  logic [7:0] wait_cnt;
`else
  typedef enum logic [1:0] {R_IDLE, R_DATA} rstate_t;
  logic unused_cfg;
  assign unused_cfg = (READ_LATENCY != 0);
`endif
  rstate_t r_state, r_next;

  logic [ID_WIDTH-1:0] r_id;
  logic [IDX_W-1:0]    r_idx, fetch_idx;
  logic [3:0]          r_len, r_cnt, fetch_cnt, fetch_len;
  logic                r_bad, fetch_bad, fetch_ok, load_beat;
  logic                ar_hs, r_hs, bad_ar;

  assign ar_hs  = arvalid_s_inf && arready_s_inf;
  assign r_hs   = rvalid_s_inf && rready_s_inf;
  assign bad_ar = (arsize_s_inf != 3'b010) || (arburst_s_inf != 2'b01);

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // Beat data is registered when a beat is presented (load_beat), so it
  // stays stable under stall and a same-cycle write is not seen.
  always_comb begin
    r_next        = r_state;
    arready_s_inf = 1'b0;
    rvalid_s_inf  = 1'b0;
    load_beat     = 1'b0;
    fetch_idx     = r_idx;
    fetch_cnt     = r_cnt;
    fetch_len     = r_len;
    fetch_bad     = r_bad;
    case (r_state)
      R_IDLE: begin
        arready_s_inf = 1'b1;
        fetch_idx     = araddr_s_inf[ADDR_WIDTH-1:2];
        fetch_cnt     = '0;
        fetch_len     = arlen_s_inf;
        fetch_bad     = bad_ar;
        if (arvalid_s_inf) begin
`ifdef AXI_RD_LATENCY_EN
          if (READ_LATENCY == 0) begin
            r_next    = R_DATA;
            load_beat = 1'b1;
          end else begin
            r_next = R_WAIT;
          end
`else
          r_next    = R_DATA;
          load_beat = 1'b1;
`endif
        end
      end
`ifdef AXI_RD_LATENCY_EN
      R_WAIT: begin
        if (wait_cnt == '0) begin
          r_next    = R_DATA;
          load_beat = 1'b1;
        end
      end
`endif
      R_DATA: begin
        rvalid_s_inf = 1'b1;
        if (rready_s_inf) begin
          if (rlast_s_inf) begin
            r_next = R_IDLE;
          end else begin
            load_beat = 1'b1;
            fetch_idx = r_idx + IDX_W'(1);
            fetch_cnt = r_cnt + 4'd1;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign fetch_ok  = !fetch_bad && (fetch_idx < MEM_LIMIT);
  assign rid_s_inf = r_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id        <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_bad       <= 1'b0;
      rdata_s_inf <= '0;
      rresp_s_inf <= 2'b00;
      rlast_s_inf <= 1'b0;
`ifdef AXI_RD_LATENCY_EN
      wait_cnt    <= '0;
`endif
    end else begin
      if (ar_hs) begin
        r_id  <= arid_s_inf;
        r_idx <= araddr_s_inf[ADDR_WIDTH-1:2];
        r_len <= arlen_s_inf;
        r_cnt <= '0;
        r_bad <= bad_ar;
`ifdef AXI_RD_LATENCY_EN
        wait_cnt <= 8'(READ_LATENCY - 1);
`endif
      end
`ifdef AXI_RD_LATENCY_EN
      if (r_state == R_WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 8'd1;
`endif
      if (r_hs && rlast_s_inf) rlast_s_inf <= 1'b0;
      if (load_beat) begin
        r_idx       <= fetch_idx;
        r_cnt       <= fetch_cnt;
        rlast_s_inf <= (fetch_cnt == fetch_len);
        rdata_s_inf <= fetch_ok ? mem[fetch_idx[MA_W-1:0]] : '0;
        rresp_s_inf <= fetch_ok ? 2'b00 : 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_slave_mem.sv
module tb_axi_burst_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int checks = 0;
  int failures = 0;
  int last_lat = 0;
  logic [31:0] exp_data [16];
  logic [1:0]  exp_resp [16];

`ifdef AXI_RD_LATENCY_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  always #5 clk = ~clk;

  axi_burst_slave_mem #(
    .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(1024), .READ_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .awid_s_inf(awid), .awaddr_s_inf(awaddr), .awlen_s_inf(awlen),
    .awsize_s_inf(awsize), .awburst_s_inf(awburst), .awvalid_s_inf(awvalid),
    .awready_s_inf(awready),
    .wdata_s_inf(wdata), .wlast_s_inf(wlast), .wvalid_s_inf(wvalid), .wready_s_inf(wready),
    .bid_s_inf(bid), .bresp_s_inf(bresp), .bvalid_s_inf(bvalid), .bready_s_inf(bready),
    .arid_s_inf(arid), .araddr_s_inf(araddr), .arlen_s_inf(arlen),
    .arsize_s_inf(arsize), .arburst_s_inf(arburst), .arvalid_s_inf(arvalid),
    .arready_s_inf(arready),
    .rid_s_inf(rid), .rdata_s_inf(rdata), .rresp_s_inf(rresp), .rlast_s_inf(rlast),
    .rvalid_s_inf(rvalid), .rready_s_inf(rready)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [2:0] size,
                             input int nbeats, input logic [31:0] base,
                             input logic [1:0] eresp, input string name);
    int n;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = 2'b01; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin tick(); n++; end
    checks++;
    if (!awready) begin
      failures++; $display("FAIL %s aw timeout", name); awvalid = 1'b0; return;
    end
    tick(); awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1; wdata = base + 32'(i); wlast = (i == nbeats - 1);
      n = 0;
      while (!wready && n < 20) begin tick(); n++; end
      if (!wready) begin
        checks++; failures++; $display("FAIL %s w timeout beat %0d", name, i);
        wvalid = 1'b0; wlast = 1'b0; return;
      end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    checks++;
    if (bvalid !== 1'b1 || bresp !== eresp || bid !== id) begin
      failures++;
      $display("FAIL %s bresp: bvalid=%b bresp=%b bid=%h, want 1 %b %h", name, bvalid, bresp, bid, eresp, id);
    end
    bready = 1'b1; tick(); bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      failures++; $display("FAIL %s b_done: bvalid=%b awready=%b, want 0 1", name, bvalid, awready);
    end
  endtask

  // Reads len+1 beats and compares against exp_data/exp_resp. With stall set,
  // every beat is first held for two cycles with rready low.
  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size,
                            input bit stall, input string name);
    int n;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = 2'b01; arvalid = 1'b1;
    rready = 1'b0;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    checks++;
    if (!arready) begin
      failures++; $display("FAIL %s ar timeout", name); arvalid = 1'b0; return;
    end
    tick(); arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!rvalid && n < 20) begin tick(); n++; end
      if (b == 0) last_lat = n + 1;
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_data[b] || rresp !== exp_resp[b] ||
          rlast !== (b == int'(len)) || rid !== id) begin
        failures++;
        $display("FAIL %s beat %0d: v=%b d=%h resp=%b last=%b id=%h, want 1 %h %b %b %h",
                 name, b, rvalid, rdata, rresp, rlast, rid, exp_data[b], exp_resp[b],
                 (b == int'(len)), id);
        if (rvalid !== 1'b1) return;
      end
      if (stall) begin
        tick(); tick();
        checks++;
        if (rvalid !== 1'b1 || rdata !== exp_data[b] || rlast !== (b == int'(len))) begin
          failures++;
          $display("FAIL %s hold beat %0d: v=%b d=%h last=%b, want 1 %h %b",
                   name, b, rvalid, rdata, rlast, exp_data[b], (b == int'(len)));
        end
      end
      rready = 1'b1; tick(); rready = 1'b0;
    end
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      failures++; $display("FAIL %s r_done: rvalid=%b arready=%b, want 0 1", name, rvalid, arready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); tick();
    checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000 ||
        bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0 || bid !== 4'h0 || rid !== 4'h0) begin
      failures++;
      $display("FAIL reset: aw/ar/w/b/rv/rl=%b bresp=%b rresp=%b rdata=%h bid=%h rid=%h, want 110000 0 0 0 0 0",
               {awready, arready, wready, bvalid, rvalid, rlast}, bresp, rresp, rdata, bid, rid);
    end
    rst = 1'b0; tick();
  endtask

  task automatic test_basic();
    write_burst(4'h5, 32'h100, 4'd3, 3'b010, 4, 32'hA0, 2'b00, "basic_wr");
    for (int i = 0; i < 4; i++) begin exp_data[i] = 32'hA0 + 32'(i); exp_resp[i] = 2'b00; end
    read_burst(4'h5, 32'h100, 4'd3, 3'b010, 1'b0, "basic_rd");
  endtask

  task automatic test_latency();
    exp_data[0] = 32'hA2; exp_resp[0] = 2'b00;
    read_burst(4'h9, 32'h108, 4'd0, 3'b010, 1'b0, "lat_rd");
    checks++;
    if (last_lat != EXP_LAT) begin
      failures++; $display("FAIL latency: got %0d cycles, want %0d", last_lat, EXP_LAT);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin exp_data[i] = 32'hA0 + 32'(i); exp_resp[i] = 2'b00; end
    read_burst(4'h6, 32'h100, 4'd3, 3'b010, 1'b1, "stall_rd");
  endtask

  task automatic test_end_boundary();
    write_burst(4'h3, 32'hFFC, 4'd1, 3'b010, 2, 32'h11, 2'b10, "edge_wr");
    exp_data[0] = 32'h11; exp_resp[0] = 2'b00;
    exp_data[1] = 32'h0;  exp_resp[1] = 2'b10;
    read_burst(4'h3, 32'hFFC, 4'd1, 3'b010, 1'b0, "edge_rd");
  endtask

  task automatic test_early_last();
    write_burst(4'h1, 32'h200, 4'd3, 3'b010, 4, 32'hC0, 2'b00, "early_fill");
    write_burst(4'h2, 32'h200, 4'd3, 3'b010, 2, 32'hB0, 2'b10, "early_wr");
    exp_data[0] = 32'hB0; exp_data[1] = 32'hB1; exp_data[2] = 32'hC2; exp_data[3] = 32'hC3;
    for (int i = 0; i < 4; i++) exp_resp[i] = 2'b00;
    read_burst(4'h2, 32'h200, 4'd3, 3'b010, 1'b0, "early_rd");
  endtask

  task automatic test_bad_size();
    write_burst(4'h7, 32'h300, 4'd0, 3'b010, 1, 32'hD0, 2'b00, "bad_fill");
    write_burst(4'h7, 32'h300, 4'd0, 3'b011, 1, 32'hE0, 2'b10, "bad_wr");
    exp_data[0] = 32'hD0; exp_resp[0] = 2'b00;
    read_burst(4'h7, 32'h300, 4'd0, 3'b010, 1'b0, "bad_chk");
    exp_data[0] = 32'h0; exp_resp[0] = 2'b10;
    exp_data[1] = 32'h0; exp_resp[1] = 2'b10;
    read_burst(4'h8, 32'h300, 4'd1, 3'b011, 1'b0, "bad_rd");
  endtask

  task automatic test_reset_mid_read();
    int n;
    arid = 4'hC; araddr = 32'h100; arlen = 4'd7; arsize = 3'b010; arburst = 2'b01;
    arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    tick(); arvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      n = 0;
      while (!rvalid && n < 20) begin tick(); n++; end
      tick();
    end
    rready = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hA2) begin
      failures++; $display("FAIL midrst beat2: rvalid=%b rdata=%h, want 1 a2", rvalid, rdata);
    end
    rst = 1'b1; tick();
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1 || rlast !== 1'b0) begin
      failures++; $display("FAIL midrst state: rvalid=%b arready=%b rlast=%b, want 0 1 0", rvalid, arready, rlast);
    end
    rst = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin exp_data[i] = 32'hA0 + 32'(i); exp_resp[i] = 2'b00; end
    read_burst(4'hD, 32'h100, 4'd3, 3'b010, 1'b0, "midrst_rd");
  endtask

  task automatic test_back_to_back();
    write_burst(4'hA, 32'h040, 4'd1, 3'b010, 2, 32'h55, 2'b00, "b2b_wr0");
    write_burst(4'hB, 32'h044, 4'd0, 3'b010, 1, 32'h77, 2'b00, "b2b_wr1");
    exp_data[0] = 32'h55; exp_data[1] = 32'h77; exp_resp[0] = 2'b00; exp_resp[1] = 2'b00;
    read_burst(4'hA, 32'h040, 4'd1, 3'b010, 1'b0, "b2b_rd");
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b0;
    rready = 1'b0;
    test_reset();
    test_basic();
    test_latency();
    test_stall();
    test_end_boundary();
    test_early_last();
    test_bad_size();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
